// File: rtl/stopwatch_seg7_scan_if.sv
// Display-stage bundle: binary time values and the blank request going in,
// multiplexed common-anode digit/segment drive coming out.
interface stopwatch_seg7_scan_if;
   logic [7:0] min_i;
   logic [7:0] sec_i;
   logic [7:0] ms_10_i;
   logic       blank_i;
   logic [5:0] an_o;
   logic [6:0] seg_o;
   logic       dp_o;

   modport master (
      output min_i, sec_i, ms_10_i, blank_i,
      input  an_o, seg_o, dp_o
   );

   modport slave (
      input  min_i, sec_i, ms_10_i, blank_i,
      output an_o, seg_o, dp_o
   );
endinterface

// File: rtl/stopwatch_seg7_scan.sv
// Time-multiplexes MM.SS.CC onto a 6-digit common-anode 7-segment display;
// inputs are snapshotted once per scan frame so a frame never mixes values.
module stopwatch_seg7_scan #(
   parameter int SCAN_DIV = 50000,
   parameter bit LZ_BLANK = 1'b1
) (
   input  logic                  clk_core,
   input  logic                  rst,
   stopwatch_seg7_scan_if.slave  bus
);
   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [DW-1:0]   div_cnt_q, div_cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic            load_pend_q, load_pend_d;
   // Snapshot fields: [0] hundredths, [1] seconds, [2] minutes.
   logic [2:0][7:0] snap_q, snap_d;
   logic [5:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;

   logic [2:0][3:0] tens_w, ones_w;

   function automatic logic [6:0] seg_lut(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         default: s = 7'h10;
      endcase
      return s;
   endfunction

   // Clamp the full 8-bit value before splitting, so 150 reads as 99.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_split
         logic [7:0] clamp_w, tens8_w, ones8_w;
         assign clamp_w     = (snap_q[gi] > 8'd99) ? 8'd99 : snap_q[gi];
         assign tens8_w     = clamp_w / 8'd10;
         assign ones8_w     = clamp_w % 8'd10;
         assign tens_w[gi]  = tens8_w[3:0];
         assign ones_w[gi]  = ones8_w[3:0];
      end
   endgenerate

   always_comb begin
      logic       div_end;
      logic       off;
      logic [3:0] digit;

      div_end     = (div_cnt_q == DW'(SCAN_DIV - 1));
      div_cnt_d   = div_end ? '0 : div_cnt_q + DW'(1);
      idx_d       = idx_q;
      if (div_end) begin
         idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end

      snap_d      = snap_q;
      load_pend_d = load_pend_q;
      if ((div_end && idx_q == 3'd5) || load_pend_q) begin
         snap_d[0]   = bus.ms_10_i;
         snap_d[1]   = bus.sec_i;
         snap_d[2]   = bus.min_i;
         load_pend_d = 1'b0;
      end

      // Odd slots carry the tens digit, even slots the ones digit.
      digit = idx_q[0] ? tens_w[idx_q[2:1]] : ones_w[idx_q[2:1]];
      off   = bus.blank_i || (LZ_BLANK && idx_q == 3'd5 && tens_w[2] == 4'd0);

      an_d  = off ? 6'h3F : ~(6'b000001 << idx_q);
      seg_d = off ? 7'h7F : seg_lut(digit);
      dp_d  = off ? 1'b1  : !(idx_q == 3'd2 || idx_q == 3'd4);
   end

   always_ff @(posedge clk_core) begin
      if (!rst) begin
         div_cnt_q   <= '0;
         idx_q       <= 3'd0;
         load_pend_q <= 1'b1;
         snap_q      <= '0;
         an_q        <= 6'h3F;
         seg_q       <= 7'h7F;
         dp_q        <= 1'b1;
      end else begin
         div_cnt_q   <= div_cnt_d;
         idx_q       <= idx_d;
         load_pend_q <= load_pend_d;
         snap_q      <= snap_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
      end
   end

   assign bus.an_o  = an_q;
   assign bus.seg_o = seg_q;
   assign bus.dp_o  = dp_q;
endmodule

// File: tb/tb_stopwatch_seg7_scan.sv
// Scoreboarded bench for stopwatch_seg7_scan: one instance with leading-zero
// blanking, one without, both fed identical scripted and random stimulus.
module tb_stopwatch_seg7_scan;
   localparam int SD = 4;
   localparam int FRAME = 6 * SD;

   typedef struct packed {
      logic [5:0] an;
      logic [6:0] seg;
      logic       dp;
   } disp_t;

   typedef struct packed {
      disp_t a;
      disp_t b;
   } exp_t;

   logic clk_core = 1'b0;
   logic rst = 1'b0;

   stopwatch_seg7_scan_if if_a ();
   stopwatch_seg7_scan_if if_b ();

   stopwatch_seg7_scan #(.SCAN_DIV(SD), .LZ_BLANK(1'b1)) dut_lz1 (
      .clk_core (clk_core),
      .rst      (rst),
      .bus      (if_a.slave)
   );

   stopwatch_seg7_scan #(.SCAN_DIV(SD), .LZ_BLANK(1'b0)) dut_lz0 (
      .clk_core (clk_core),
      .rst      (rst),
      .bus      (if_b.slave)
   );

   always #5 clk_core = ~clk_core;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state: cycles since reset release and the displayed values.
   int k = 0;
   int snap_mn = 0, snap_sc = 0, snap_ms = 0;
   int mn = 0, sc = 0, ms = 0;
   bit bl = 1'b0;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   function automatic int clamp99(input int v);
      return (v > 99) ? 99 : v;
   endfunction

   function automatic disp_t decode(input int idx, input int vm, input int vs,
                                    input int vc, input bit blank, input bit lz);
      disp_t d;
      int    digit;
      case (idx)
         0:       digit = clamp99(vc) % 10;
         1:       digit = clamp99(vc) / 10;
         2:       digit = clamp99(vs) % 10;
         3:       digit = clamp99(vs) / 10;
         4:       digit = clamp99(vm) % 10;
         default: digit = clamp99(vm) / 10;
      endcase
      if (blank || (lz && idx == 5 && digit == 0)) begin
         d.an = 6'h3F; d.seg = 7'h7F; d.dp = 1'b1;
      end else begin
         d.an  = 6'h3F ^ (6'(1) << idx);
         d.seg = seg_tab[digit];
         d.dp  = !(idx == 2 || idx == 4);
      end
      return d;
   endfunction

   task automatic step(input bit r);
      exp_t e;
      int   idx;
      @(negedge clk_core);
      rst = r;
      if_a.min_i = 8'(mn); if_a.sec_i = 8'(sc); if_a.ms_10_i = 8'(ms); if_a.blank_i = bl;
      if_b.min_i = 8'(mn); if_b.sec_i = 8'(sc); if_b.ms_10_i = 8'(ms); if_b.blank_i = bl;
      if (!r) begin
         e.a = '{an: 6'h3F, seg: 7'h7F, dp: 1'b1};
         e.b = e.a;
         k = 0; snap_mn = 0; snap_sc = 0; snap_ms = 0;
      end else begin
         idx = (k / SD) % 6;
         e.a = decode(idx, snap_mn, snap_sc, snap_ms, bl, 1'b1);
         e.b = decode(idx, snap_mn, snap_sc, snap_ms, bl, 1'b0);
         if (k == 0 || (k % FRAME) == FRAME - 1) begin
            snap_mn = mn; snap_sc = sc; snap_ms = ms;
         end
         k++;
      end
      exp_q.push_back(e);
   endtask

   task automatic cmp(input string name, input int act, input int req);
      n_checks++;
      if (act == req) n_pass++;
      else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
   endtask

   // Monitor: each output update is compared against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_core);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("an_lz1",  int'(if_a.an_o),  int'(e.a.an));
            cmp("seg_lz1", int'(if_a.seg_o), int'(e.a.seg));
            cmp("dp_lz1",  int'(if_a.dp_o),  int'(e.a.dp));
            cmp("an_lz0",  int'(if_b.an_o),  int'(e.b.an));
            cmp("seg_lz0", int'(if_b.seg_o), int'(e.b.seg));
            cmp("dp_lz0",  int'(if_b.dp_o),  int'(e.b.dp));
            $display("t=%0t an=%h/%h seg=%h/%h dp=%0b/%0b", $time,
                     if_a.an_o, if_b.an_o, if_a.seg_o, if_b.seg_o, if_a.dp_o, if_b.dp_o);
         end
      end
   end

   initial begin
      if_a.min_i = '0; if_a.sec_i = '0; if_a.ms_10_i = '0; if_a.blank_i = 1'b0;
      if_b.min_i = '0; if_b.sec_i = '0; if_b.ms_10_i = '0; if_b.blank_i = 1'b0;

      mn = 12; sc = 34; ms = 56; bl = 1'b0;
      repeat (5) step(1'b0);
      repeat (36) step(1'b1);
      sc = 7;                       // mid-frame change, visible only next frame
      repeat (36) step(1'b1);
      mn = 150;                     // clamps to 99
      repeat (24) step(1'b1);
      mn = 5;                       // leading-zero slot differs between instances
      repeat (24) step(1'b1);
      bl = 1'b1;
      repeat (10) step(1'b1);
      bl = 1'b0;
      repeat (28) step(1'b1);       // lands on idx 3, div_cnt 2
      mn = 42; sc = 17; ms = 88;
      step(1'b0);
      repeat (30) step(1'b1);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) mn = $urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 12);
         if ($urandom_range(0, 7) == 0) sc = $urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 59);
         if ($urandom_range(0, 3) == 0) ms = $urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 99);
         bl = ($urandom_range(0, 15) == 0);
         step($urandom_range(0, 99) != 0);
      end

      @(posedge clk_core);
      #3;
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d pending expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
